// File: rtl/ihp_sram_ctrl_pkg.sv
// Shared types for the IHP 1024x32 SRAM port controller: FSM states,
// requester ids and the read-return tag carried alongside each macro read.
package ihp_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      WAIT_CFG = 2'd1,
      RUN      = 2'd2
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
   } tag_t;

   localparam int NUM_PORTS = 2;
   // Command register stage plus the macro's own output register.
   localparam int RD_LAT    = 2;

   function automatic port_e other_port(port_e p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/ihp_sram_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the port that wins a tie
// and moves to the other port only when a grant is actually issued.
module ihp_sram_rr_arb
   import ihp_sram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   port_e ptr_q, ptr_d;

   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (en) begin
         if (req[0] && req[1]) begin
            gnt = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
      if (gnt[0]) begin
         ptr_d = other_port(PORT_A);
      end else if (gnt[1]) begin
         ptr_d = other_port(PORT_B);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= PORT_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ihp_sram_port_ctrl.sv
// Two-requester controller for the IHP 1024x32 SRAM macro: optional zero-fill
// sweep, round-robin arbitration, registered macro strobes, tagged read return.
module ihp_sram_port_ctrl
   import ihp_sram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int INIT_CLEAR = 1
) (
   input  logic              UserCLK,
   input  logic              RST,
   input  logic              configured,

   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [DATA_W-1:0] a_wmask,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [DATA_W-1:0] b_wmask,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,

   output logic              init_busy,

   output logic              sram_men,
   output logic              sram_wen,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   output logic [DATA_W-1:0] sram_bm,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_e                             state_q, state_d;
   logic [ADDR_W-1:0]                  cnt_q, cnt_d;
   logic                               men_q, men_d;
   logic                               wen_q, wen_d;
   logic                               ren_q, ren_d;
   logic                               busy_q, busy_d;
   logic [ADDR_W-1:0]                  addr_q, addr_d;
   logic [DATA_W-1:0]                  din_q, din_d;
   logic [DATA_W-1:0]                  bm_q, bm_d;
   tag_t [RD_LAT-1:0]                  tag_q, tag_d;
   logic [NUM_PORTS-1:0]               rvalid_q, rvalid_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_q, rdata_d;

   logic [NUM_PORTS-1:0] req, gnt;
   logic                 sel_b;
   logic                 req_we;
   logic [ADDR_W-1:0]    req_addr;
   logic [DATA_W-1:0]    req_wdata;
   logic [DATA_W-1:0]    req_wmask;

   assign req = {b_valid, a_valid};

   ihp_sram_rr_arb u_arb (
      .clk (UserCLK),
      .rst (RST),
      .req (req),
      .en  (state_q == RUN),
      .gnt (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   assign sel_b     = gnt[1];
   assign req_we    = sel_b ? b_we    : a_we;
   assign req_addr  = sel_b ? b_addr  : a_addr;
   assign req_wdata = sel_b ? b_wdata : a_wdata;
   assign req_wmask = sel_b ? b_wmask : a_wmask;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      men_d   = 1'b0;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      busy_d  = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      bm_d    = bm_q;
      tag_d[0] = '{valid: 1'b0, port: PORT_A};
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      case (state_q)
         INIT: begin
            men_d  = 1'b1;
            wen_d  = 1'b1;
            bm_d   = '1;
            din_d  = '0;
            addr_d = cnt_q;
            busy_d = 1'b1;
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = WAIT_CFG;
            end
         end
         WAIT_CFG: begin
            if (configured) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Losing configured later is ignored on purpose: traffic keeps flowing.
            if (|gnt) begin
               men_d  = 1'b1;
               wen_d  = req_we;
               ren_d  = !req_we;
               addr_d = req_addr;
               if (req_we) begin
                  din_d = req_wdata;
                  bm_d  = req_wmask;
               end else begin
                  bm_d     = '0;
                  tag_d[0] = '{valid: 1'b1, port: sel_b ? PORT_B : PORT_A};
               end
            end
         end
         default: state_d = WAIT_CFG;
      endcase
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      localparam port_e PID = (p == 0) ? PORT_A : PORT_B;
      assign rvalid_d[p] = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == PID);
      assign rdata_d[p]  = rvalid_d[p] ? sram_dout : rdata_q[p];
   end

   always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
         state_q  <= (INIT_CLEAR != 0) ? INIT : WAIT_CFG;
         cnt_q    <= '0;
         men_q    <= 1'b0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         bm_q     <= '0;
         tag_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         men_q    <= men_d;
         wen_q    <= wen_d;
         ren_q    <= ren_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         bm_q     <= bm_d;
         tag_q    <= tag_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign init_busy = busy_q;
   assign sram_men  = men_q;
   assign sram_wen  = wen_q;
   assign sram_ren  = ren_q;
   assign sram_addr = addr_q;
   assign sram_din  = din_q;
   assign sram_bm   = bm_q;
   assign a_rvalid  = rvalid_q[0];
   assign a_rdata   = rdata_q[0];
   assign b_rvalid  = rvalid_q[1];
   assign b_rdata   = rdata_q[1];

endmodule

// File: tb/tb_ihp_sram_port_ctrl.sv
// Self-checking bench for ihp_sram_port_ctrl: behavioural SRAM macro, a
// transaction-level reference (memory array + response queue), directed
// vectors and randomized two-port traffic.
module tb_ihp_sram_port_ctrl;

   localparam int AW         = 10;
   localparam int DW         = 32;
   localparam int INIT_DEPTH = 1024;
   localparam int NV         = 13;

   logic          UserCLK, RST, configured;
   logic          a_valid, a_ready, a_we, a_rvalid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_wmask, a_rdata;
   logic          b_valid, b_ready, b_we, b_rvalid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_wmask, b_rdata;
   logic          init_busy, sram_men, sram_wen, sram_ren;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_bm, sram_dout;

   ihp_sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1)) dut (
      .UserCLK(UserCLK), .RST(RST), .configured(configured),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .init_busy(init_busy),
      .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
      .sram_dout(sram_dout)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   // Behavioural macro: samples strobes on the rising edge, dout registered.
   logic [DW-1:0] mem [0:INIT_DEPTH-1];
   always @(posedge UserCLK) begin
      if (sram_men) begin
         if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
         if (sram_ren) sram_dout <= mem[sram_addr];
      end
   end

   typedef struct {
      bit            port;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] wmask;
      logic [DW-1:0] exp;
   } vec_t;

   typedef struct {
      int            due;
      bit            port;
      logic [DW-1:0] data;
      bit            tchk;
      logic [DW-1:0] tval;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            edge_no = 0;
   int            init_left;
   bit            cfg_seen, prefer_b, last_ga, last_gb, chk_din;
   bit            cur_tchk;
   logic [DW-1:0] cur_tval;
   logic [DW-1:0] ref_mem [0:INIT_DEPTH-1];
   logic [DW-1:0] exp_rd [2];
   exp_t          expq [$];
   logic          exp_men, exp_wen, exp_ren;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_din, exp_bm;
   vec_t          tbl [NV];

   function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
      end
   endfunction

   function automatic vec_t mkv(bit port, bit we, logic [AW-1:0] addr,
                                logic [DW-1:0] wdata, logic [DW-1:0] wmask, logic [DW-1:0] exp);
      vec_t v;
      v.port = port; v.we = we; v.addr = addr;
      v.wdata = wdata; v.wmask = wmask; v.exp = exp;
      return v;
   endfunction

   // One clock: check ready against the arbitration rules, account the
   // accepted transaction, advance, then check strobes and read returns.
   task automatic step();
      bit            ga, gb, pb, we, was_init;
      logic [AW-1:0] ad;
      logic [DW-1:0] wd, wm;
      logic [1:0]    exp_v;
      exp_t          e;
      int            idx;
      #1;
      ga = 1'b0; gb = 1'b0;
      if (init_left == 0 && cfg_seen) begin
         if (a_valid && b_valid) begin
            ga = !prefer_b; gb = prefer_b;
         end else begin
            ga = a_valid; gb = b_valid;
         end
      end
      chk("a_ready", 32'(a_ready), 32'(ga));
      chk("b_ready", 32'(b_ready), 32'(gb));
      last_ga = ga; last_gb = gb;
      pb = gb;
      we = pb ? b_we    : a_we;
      ad = pb ? b_addr  : a_addr;
      wd = pb ? b_wdata : a_wdata;
      wm = pb ? b_wmask : a_wmask;
      was_init = (init_left > 0);
      idx = INIT_DEPTH - init_left;
      if (was_init) begin
         exp_men = 1'b1; exp_wen = 1'b1; exp_ren = 1'b0;
         exp_addr = AW'(idx); exp_din = '0; exp_bm = '1; chk_din = 1'b1;
         init_left--;
      end else begin
         if (!cfg_seen && configured) cfg_seen = 1'b1;
         if (ga || gb) begin
            exp_men = 1'b1; exp_wen = we; exp_ren = !we; exp_addr = ad;
            if (we) begin
               exp_din = wd; exp_bm = wm; chk_din = 1'b1;
               ref_mem[ad] = (ref_mem[ad] & ~wm) | (wd & wm);
            end else begin
               exp_bm = '0; chk_din = 1'b0;
               e.due = edge_no + 3; e.port = pb; e.data = ref_mem[ad];
               e.tchk = cur_tchk; e.tval = cur_tval;
               expq.push_back(e);
            end
            prefer_b = !pb;
         end else begin
            exp_men = 1'b0; exp_wen = 1'b0; exp_ren = 1'b0; chk_din = 1'b0;
         end
      end
      cur_tchk = 1'b0;
      @(posedge UserCLK);
      #1;
      edge_no++;
      chk("sram_men", 32'(sram_men), 32'(exp_men));
      chk("sram_wen", 32'(sram_wen), 32'(exp_wen));
      chk("sram_ren", 32'(sram_ren), 32'(exp_ren));
      chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      chk("sram_bm", sram_bm, exp_bm);
      if (chk_din) chk("sram_din", sram_din, exp_din);
      chk("init_busy", 32'(init_busy), 32'(was_init));
      exp_v = 2'b00;
      if (expq.size() > 0 && expq[0].due == edge_no) begin
         e = expq.pop_front();
         exp_v[e.port] = 1'b1;
         exp_rd[e.port] = e.data;
         if (e.tchk) chk("tbl_rdata", e.port ? b_rdata : a_rdata, e.tval);
      end
      chk("a_rvalid", 32'(a_rvalid), 32'(exp_v[0]));
      chk("b_rvalid", 32'(b_rvalid), 32'(exp_v[1]));
      chk("a_rdata", a_rdata, exp_rd[0]);
      chk("b_rdata", b_rdata, exp_rd[1]);
   endtask

   task automatic chk_reset_outs();
      chk("rst_men", 32'(sram_men), 32'd0);
      chk("rst_wen", 32'(sram_wen), 32'd0);
      chk("rst_ren", 32'(sram_ren), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_din", sram_din, 32'd0);
      chk("rst_bm", sram_bm, 32'd0);
      chk("rst_busy", 32'(init_busy), 32'd0);
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
   endtask

   task automatic do_reset(bit cfg);
      RST = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; configured = cfg;
      #1;
      chk_reset_outs();
      repeat (2) begin
         @(posedge UserCLK);
         #1;
      end
      chk_reset_outs();
      RST = 1'b0;
      init_left = INIT_DEPTH; cfg_seen = 1'b0; prefer_b = 1'b0;
      expq.delete();
      exp_rd[0] = '0; exp_rd[1] = '0;
      exp_addr = '0; exp_din = '0; exp_bm = '0;
      for (int i = 0; i < INIT_DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic wait_run();
      for (int i = 0; i < INIT_DEPTH + 8 && !(init_left == 0 && cfg_seen); i++) step();
   endtask

   function automatic logic [DW-1:0] pick_mask();
      case ($urandom_range(2))
         0:       return '0;
         1:       return '1;
         default: return DW'($urandom);
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cnt;
      bit pa, pbq;
      RST = 1'b0; configured = 1'b0; cur_tchk = 1'b0; cur_tval = '0;
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;

      tbl[0]  = mkv(1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0);
      tbl[1]  = mkv(1'b0, 1'b0, 10'h3FF, 32'h0,        32'h0,        32'hDEADBEEF);
      tbl[2]  = mkv(1'b1, 1'b1, 10'h010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
      tbl[3]  = mkv(1'b1, 1'b1, 10'h010, 32'h00000000, 32'h0000FFFF, 32'h0);
      tbl[4]  = mkv(1'b1, 1'b0, 10'h010, 32'h0,        32'h0,        32'hFFFF0000);
      tbl[5]  = mkv(1'b0, 1'b0, 10'h005, 32'h0,        32'h0,        32'h00000000);
      tbl[6]  = mkv(1'b0, 1'b1, 10'h011, 32'h12345678, 32'h00000000, 32'h0);
      tbl[7]  = mkv(1'b0, 1'b0, 10'h011, 32'h0,        32'h0,        32'h00000000);
      tbl[8]  = mkv(1'b1, 1'b1, 10'h000, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0);
      tbl[9]  = mkv(1'b0, 1'b0, 10'h000, 32'h0,        32'h0,        32'hA5A5A5A5);
      tbl[10] = mkv(1'b1, 1'b0, 10'h3FF, 32'h0,        32'h0,        32'hDEADBEEF);
      tbl[11] = mkv(1'b0, 1'b1, 10'h3FF, 32'h00000000, 32'hFF000000, 32'h0);
      tbl[12] = mkv(1'b1, 1'b0, 10'h3FF, 32'h0,        32'h0,        32'h00ADBEEF);

      // Reset, zero-fill sweep with configured already high.
      do_reset(1'b1);
      busy_cnt = 0;
      for (int i = 0; i < INIT_DEPTH + 4; i++) begin
         step();
         if (init_busy) busy_cnt++;
      end
      chk("init_busy_cycles", 32'(busy_cnt), 32'(INIT_DEPTH));
      wait_run();

      // Both ports valid: grants alternate starting with A, macro busy every cycle.
      a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h005;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 10'h006;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("alt_a_ready", 32'(a_ready), 32'((i % 2) == 0));
         chk("alt_b_ready", 32'(b_ready), 32'((i % 2) == 1));
         step();
         chk("alt_men", 32'(sram_men), 32'd1);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) step();

      // Table vectors, one per cycle back to back.
      for (int i = 0; i < NV; i++) begin
         a_valid = 1'b0; b_valid = 1'b0;
         if (tbl[i].port) begin
            b_valid = 1'b1; b_we = tbl[i].we; b_addr = tbl[i].addr;
            b_wdata = tbl[i].wdata; b_wmask = tbl[i].wmask;
         end else begin
            a_valid = 1'b1; a_we = tbl[i].we; a_addr = tbl[i].addr;
            a_wdata = tbl[i].wdata; a_wmask = tbl[i].wmask;
         end
         cur_tchk = !tbl[i].we; cur_tval = tbl[i].exp;
         step();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) step();

      // Fabric not yet configured: request held off, then accepted.
      do_reset(1'b0);
      for (int i = 0; i < INIT_DEPTH; i++) step();
      a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h003;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("cfg_hold_a_ready", 32'(a_ready), 32'd0);
         step();
      end
      configured = 1'b1;
      #1;
      chk("cfg_rise_a_ready", 32'(a_ready), 32'd0);
      step();
      #1;
      chk("cfg_accept_a_ready", 32'(a_ready), 32'd1);
      step();
      a_valid = 1'b0;
      repeat (4) step();

      // Reset right after a B read is accepted: its response must never appear.
      b_valid = 1'b1; b_we = 1'b0; b_addr = 10'h3FF;
      step();
      b_valid = 1'b0;
      do_reset(1'b1);
      wait_run();

      // Randomized two-port traffic over a small address window.
      pa = 1'b0; pbq = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!pa && $urandom_range(9) < 7) begin
            pa = 1'b1; a_we = 1'($urandom_range(1)); a_addr = AW'($urandom_range(15));
            a_wdata = DW'($urandom); a_wmask = pick_mask();
         end
         if (!pbq && $urandom_range(9) < 7) begin
            pbq = 1'b1; b_we = 1'($urandom_range(1)); b_addr = AW'($urandom_range(15));
            b_wdata = DW'($urandom); b_wmask = pick_mask();
         end
         a_valid = pa; b_valid = pbq;
         step();
         if (last_ga) pa = 1'b0;
         if (last_gb) pbq = 1'b0;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
